// File: rtl/lsb_stego_engine.sv
// lsb_stego_engine: embeds a payload into, or extracts it from, the low NLSB bits of each sample in a frame.
// Ports:
//   in_clk, in_rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid, in_mode          frame offered; mode 0 = embed, 1 = extract (captured on accept)
//   in_frame, in_message       FRAME_SIZE samples of BPS bits; NLSB payload bits per sample
//   in_ack                     downstream has taken the result (only honoured while out_valid)
//   out_accept, out_valid      ready for a new frame; result available and held until in_ack
//   out_frame, out_message     resulting frame and payload
//   out_frame_cnt              frames completed, wraps at 16 bits
module lsb_stego_engine #(
    parameter int BPS        = 16,
    parameter int FRAME_SIZE = 8,
    parameter int NLSB       = 1
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_valid,
    input  logic                       in_mode,
    input  logic [FRAME_SIZE*BPS-1:0]  in_frame,
    input  logic [FRAME_SIZE*NLSB-1:0] in_message,
    input  logic                       in_ack,
    output logic                       out_accept,
    output logic                       out_valid,
    output logic [FRAME_SIZE*BPS-1:0]  out_frame,
    output logic [FRAME_SIZE*NLSB-1:0] out_message,
    output logic [15:0]                out_frame_cnt
);
    localparam int IW = $clog2(FRAME_SIZE + 1);
    // idx runs 0..FRAME_SIZE; the extra terminal count gives the FRAME_SIZE+1 cycle latency
    localparam logic [IW-1:0] LAST = IW'(FRAME_SIZE);
    typedef enum logic [1:0] {IDLE, CODE, DONE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic mode;
    // rdy holds off out_accept until the first edge after reset release
    logic rdy;
    logic take;
    logic [FRAME_SIZE*BPS-1:0] frm;
    logic [FRAME_SIZE*NLSB-1:0] msg;
    logic [15:0] cnt;
    always_comb begin
        take = state == IDLE && rdy && in_valid;
        state_nxt = take ? CODE :
                    (state == CODE && idx == LAST) ? DONE :
                    (state == DONE && in_ack) ? IDLE : state;
        out_accept = state == IDLE && rdy;
        out_valid = state == DONE;
        out_frame = frm;
        out_message = msg;
        out_frame_cnt = cnt;
    end
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
            idx <= '0;
            mode <= 1'b0;
            rdy <= 1'b0;
            frm <= '0;
            msg <= '0;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            rdy <= 1'b1;
            if (take) begin
                frm <= in_frame;
                msg <= in_message;
                mode <= in_mode;
                idx <= '0;
            end else if (state == CODE && idx != LAST) begin
                idx <= idx + 1'b1;
                if (mode)
                    msg[idx*NLSB +: NLSB] <= frm[idx*BPS +: NLSB];
                else
                    frm[idx*BPS +: NLSB] <= msg[idx*NLSB +: NLSB];
            end
            if (state == DONE && in_ack)
                cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_lsb_stego_engine.sv
// tb_lsb_stego_engine: directed checks of embed/extract, latency, hold, reset and counter wrap.
module tb_lsb_stego_engine;
    localparam int FS = 8;
    logic in_clk = 1'b0;
    logic in_rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic in_ack = 1'b0;
    logic [FS*16-1:0] in_frame = '0;
    logic [FS*1-1:0] in_message1 = '0;
    logic [FS*2-1:0] in_message2 = '0;
    logic out_accept1, out_valid1, out_accept2, out_valid2;
    logic [FS*16-1:0] out_frame1, out_frame2;
    logic [FS*1-1:0] out_message1;
    logic [FS*2-1:0] out_message2;
    logic [15:0] out_frame_cnt1, out_frame_cnt2;
    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic [15:0] exp_cnt = '0;

    always #5 in_clk = ~in_clk;

    lsb_stego_engine #(.BPS(16), .FRAME_SIZE(FS), .NLSB(1)) u1 (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .in_mode(in_mode),
        .in_frame(in_frame), .in_message(in_message1), .in_ack(in_ack),
        .out_accept(out_accept1), .out_valid(out_valid1), .out_frame(out_frame1),
        .out_message(out_message1), .out_frame_cnt(out_frame_cnt1));

    lsb_stego_engine #(.BPS(16), .FRAME_SIZE(FS), .NLSB(2)) u2 (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .in_mode(in_mode),
        .in_frame(in_frame), .in_message(in_message2), .in_ack(in_ack),
        .out_accept(out_accept2), .out_valid(out_valid2), .out_frame(out_frame2),
        .out_message(out_message2), .out_frame_cnt(out_frame_cnt2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one frame, scramble the inputs and pulse in_ack while it is coded, and
    // return once out_valid is seen (bounded), leaving the result held in DONE.
    task automatic run_frame(input logic mode, input logic [127:0] frame,
                             input logic [15:0] msg2, input logic [7:0] msg1);
        @(negedge in_clk);
        in_frame = frame;
        in_message2 = msg2;
        in_message1 = msg1;
        in_mode = mode;
        in_valid = 1'b1;
        chk("accept_ready", out_accept2, 1'b1);
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        in_frame = ~frame;
        in_message2 = ~msg2;
        in_message1 = ~msg1;
        in_mode = ~mode;
        in_ack = 1'b1;
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            @(posedge in_clk);
            #1;
            lat++;
        end
        in_ack = 1'b0;
        chk("latency", lat, FS + 1);
        chk("cnt_ack_ignored", out_frame_cnt2, exp_cnt);
    endtask

    task automatic ack_frame();
        @(negedge in_clk);
        in_ack = 1'b1;
        @(posedge in_clk);
        #1;
        in_ack = 1'b0;
        exp_cnt++;
        chk("valid_drop", out_valid2, 1'b0);
        chk("cnt_after_ack", out_frame_cnt2, exp_cnt);
    endtask

    initial begin
        int t0;
        int t1;
        logic seen;
        logic prev;
        #3;
        chk("rst_valid", out_valid2, 1'b0);
        chk("rst_accept", out_accept2, 1'b0);
        chk("rst_frame", out_frame2, '0);
        chk("rst_cnt", out_frame_cnt2, '0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        #1;
        chk("accept_before_edge", out_accept2, 1'b0);
        @(posedge in_clk);
        #1;
        chk("accept_after_edge", out_accept2, 1'b1);

        run_frame(1'b0, {FS{16'hFFFF}}, 16'h5555, 8'b1010_1010);
        chk("embed1_frame", out_frame1, 128'hFFFF_FFFE_FFFF_FFFE_FFFF_FFFE_FFFF_FFFE);
        chk("embed1_msg", out_message1, 8'hAA);
        ack_frame();

        run_frame(1'b0, {FS{16'h1234}}, 16'hFFFF, 8'h00);
        chk("embed2_frame", out_frame2, {FS{16'h1237}});
        chk("embed2_msg", out_message2, 16'hFFFF);
        ack_frame();

        run_frame(1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 16'h0000, 8'h00);
        chk("extract_msg", out_message2, 16'hE4E4);
        chk("extract_frame", out_frame2, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        ack_frame();

        run_frame(1'b0, {FS{16'hABCD}}, 16'h0000, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge in_clk);
            in_valid = i[0];
            in_mode = ~i[1];
            in_frame = {4{$urandom}};
            in_message2 = 16'($urandom);
            @(posedge in_clk);
            #1;
            chk("hold_frame", out_frame2, {FS{16'hABCC}});
        end
        in_valid = 1'b0;
        chk("hold_msg", out_message2, 16'h0000);
        chk("hold_valid", out_valid2, 1'b1);
        chk("hold_accept", out_accept2, 1'b0);
        chk("hold_cnt", out_frame_cnt2, exp_cnt);
        ack_frame();

        @(negedge in_clk);
        in_valid = 1'b1;
        in_ack = 1'b1;
        in_mode = 1'b0;
        t0 = -1;
        t1 = -1;
        prev = 1'b0;
        for (int c = 0; c < 100 && t1 < 0; c++) begin
            @(posedge in_clk);
            #1;
            if (out_valid2 && !prev) begin
                if (t0 < 0) t0 = c;
                else t1 = c;
            end
            prev = out_valid2;
        end
        @(negedge in_clk);
        in_valid = 1'b0;
        in_ack = 1'b0;
        chk("b2b_period", t1 - t0, FS + 3);
        exp_cnt++;
        ack_frame();

        @(negedge in_clk);
        force u2.cnt = 16'hFFFF;
        #1;
        release u2.cnt;
        exp_cnt = 16'hFFFF;
        run_frame(1'b0, {FS{16'h0F0F}}, 16'h0000, 8'h00);
        ack_frame();
        chk("cnt_wrap", out_frame_cnt2, 16'h0000);

        @(negedge in_clk);
        in_frame = {FS{16'h5A5A}};
        in_message2 = 16'hFFFF;
        in_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge in_clk);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid2, 1'b0);
        chk("midrst_accept", out_accept2, 1'b0);
        chk("midrst_frame", out_frame2, '0);
        chk("midrst_msg", out_message2, '0);
        chk("midrst_cnt", out_frame_cnt2, '0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        exp_cnt = '0;
        seen = 1'b0;
        repeat (FS + 3) begin
            @(posedge in_clk);
            #1;
            seen = seen | out_valid2;
        end
        chk("midrst_no_valid", seen, 1'b0);
        run_frame(1'b0, {FS{16'h1234}}, 16'hFFFF, 8'h00);
        chk("post_rst_frame", out_frame2, {FS{16'h1237}});
        ack_frame();
        chk("post_rst_cnt", out_frame_cnt2, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
